// File: rtl/waybit_array.sv
// rtl/waybit_array.sv - per-set way-bit store with masked RMW writes and sequenced clear sweep
//
// Purpose: holds one bit per way per set (valid/dirty/LRU-style state) for the
// L1 tag/state path. The read port is asynchronous and also reports population
// count and all-ones status. A clear sweep zeroes CLR_ROWS sets per cycle; it
// starts on reset and on clr_req while idle.
//
// Ports:
//   clk       clock, all state updates on posedge
//   reset     synchronous active-low reset (restarts the clear sweep)
//   ra        read set address
//   rd        read data (0 while busy)
//   rd_pop    number of ones in rd
//   rd_all    rd is all ones
//   wr        write request (dropped while busy or when clr_req is accepted)
//   wa        write set address
//   way_mask  ways affected by the write
//   wr_op     00 load in, 01 set, 10 clear, 11 invert (masked bits only)
//   in        data bit for op 00
//   clr_req   start a clear sweep (ignored while busy)
//   busy      sweep in progress
//   clr_done  one-cycle pulse after the final sweep row group
module waybit_array #(
  parameter int SETS     = 8192,
  parameter int WAYS     = 4,
  parameter int CLR_ROWS = 8,
  localparam int AW      = $clog2(SETS),
  localparam int PW      = $clog2(WAYS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ra,
  output logic [WAYS-1:0] rd,
  output logic [PW-1:0]   rd_pop,
  output logic            rd_all,
  input  logic            wr,
  input  logic [AW-1:0]   wa,
  input  logic [WAYS-1:0] way_mask,
  input  logic [1:0]      wr_op,
  input  logic            in,
  input  logic            clr_req,
  output logic            busy,
  output logic            clr_done
);

  // Sweep pointer always sits on a CLR_ROWS-aligned boundary, so the rows of
  // a group are addressed by OR-ing the row offset into the low bits.
  localparam logic [AW-1:0] PTR_LAST = AW'(SETS - CLR_ROWS);
  localparam logic [AW-1:0] PTR_STEP = AW'(CLR_ROWS);

  logic [WAYS-1:0] mem_q [SETS];

  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic            wr_accept;
  logic [WAYS-1:0] wr_cur;
  logic [WAYS-1:0] wr_bits;
  logic [WAYS-1:0] wr_val;

  // Sweep sequencing
  always_comb begin
    ptr_d  = ptr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      if (ptr_q == PTR_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        ptr_d  = '0;
      end else begin
        ptr_d = ptr_q + PTR_STEP;
      end
    end else if (clr_req) begin
      busy_d = 1'b1;
      ptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Masked read-modify-write value; the clear sweep wins over any write.
  assign wr_accept = !busy_q && !clr_req && wr;
  assign wr_cur    = mem_q[wa];

  always_comb begin
    wr_bits = '0;
    case (wr_op)
      2'b00:   wr_bits = {WAYS{in}};
      2'b01:   wr_bits = '1;
      2'b10:   wr_bits = '0;
      default: wr_bits = ~wr_cur;
    endcase
    wr_val = (wr_cur & ~way_mask) | (wr_bits & way_mask);
  end

  // Array has no reset of its own; the sweep that reset starts clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (busy_q) begin
        for (int k = 0; k < CLR_ROWS; k++) begin
          mem_q[ptr_q | AW'(k)] <= '0;
        end
      end else if (wr_accept) begin
        mem_q[wa] <= wr_val;
      end
    end
  end

  // Read port and status
  assign rd = busy_q ? '0 : mem_q[ra];

  always_comb begin
    rd_pop = '0;
    for (int i = 0; i < WAYS; i++) begin
      rd_pop = rd_pop + PW'(rd[i]);
    end
  end

  assign rd_all   = &rd;
  assign busy     = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_waybit_array.sv
// tb/tb_waybit_array.sv - directed self-checking bench for waybit_array
module tb_waybit_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] ra, wa;
  logic [3:0]  rd, way_mask;
  logic [2:0]  rd_pop;
  logic        rd_all, wr, in_b, clr_req, busy, clr_done;
  logic [1:0]  wr_op;

  logic [5:0]  ra2, wa2;
  logic [7:0]  rd2, way_mask2;
  logic [3:0]  rd_pop2;
  logic        rd_all2, wr2, in2, clr_req2, busy2, clr_done2;
  logic [1:0]  wr_op2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  waybit_array u_dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_pop(rd_pop), .rd_all(rd_all),
    .wr(wr), .wa(wa), .way_mask(way_mask), .wr_op(wr_op), .in(in_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  waybit_array #(.SETS(64), .WAYS(8), .CLR_ROWS(64)) u_dut2 (
    .clk(clk), .reset(reset), .ra(ra2), .rd(rd2), .rd_pop(rd_pop2), .rd_all(rd_all2),
    .wr(wr2), .wa(wa2), .way_mask(way_mask2), .wr_op(wr_op2), .in(in2),
    .clr_req(clr_req2), .busy(busy2), .clr_done(clr_done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one write at the current negedge; it lands on the following posedge.
  task automatic do_write(input logic [12:0] a, input logic [3:0] m,
                          input logic [1:0] op, input logic d);
    wr = 1'b1; wa = a; way_mask = m; wr_op = op; in_b = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [12:0] a, input logic [3:0] exp);
    ra = a;
    #1;
    check(tag, rd, exp);
  endtask

  // Called at a negedge where busy is already observed high. Counts busy
  // samples until it drops; optionally pulses clr_req or reset at a given
  // sample. A reset restarts the count from the new sweep.
  task automatic sweep_check(input string tag, input int exp_len,
                             input int req_at, input int rst_at);
    int n = 0;
    int early = 0;
    int rst_pt = rst_at;
    while (busy === 1'b1 && n < 5000) begin
      if (clr_done !== 1'b0) early++;
      n++;
      if (n == req_at) clr_req = 1'b1;
      if (n == rst_pt) begin
        reset = 1'b0;
        rst_pt = -1;
      end
      @(negedge clk);
      clr_req = 1'b0;
      if (reset == 1'b0) begin
        reset = 1'b1;
        n = 0;
      end
    end
    check({tag, " busy_len"}, n, exp_len);
    check({tag, " no_early_done"}, early, 0);
    check({tag, " done"}, clr_done, 1'b1);
    @(negedge clk);
    check({tag, " done_pulse"}, clr_done, 1'b0);
  endtask

  initial begin
    reset = 1'b0; ra = '0; wa = '0; way_mask = '0; wr = 1'b0; wr_op = '0;
    in_b = 1'b0; clr_req = 1'b0;
    ra2 = '0; wa2 = '0; way_mask2 = '0; wr2 = 1'b0; wr_op2 = '0; in2 = 1'b0;
    clr_req2 = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst busy", busy, 1'b1);
    check("rst done", clr_done, 1'b0);
    check("rst rd", rd, 4'h0);
    check("rst rd_pop", rd_pop, 3'd0);
    check("rst rd_all", rd_all, 1'b0);
    reset = 1'b1;
    sweep_check("rst", 1024, -1, -1);
    read_check("rst rd_1fff", 13'h1FFF, 4'h0);

    // Masked RMW on one set; rd shows old value before the edge
    ra = 13'h0A5;
    wr = 1'b1; wa = 13'h0A5; way_mask = 4'b0100; wr_op = 2'b00; in_b = 1'b1;
    #1;
    check("no_bypass", rd, 4'h0);
    @(negedge clk);
    wr = 1'b0;
    read_check("op00", 13'h0A5, 4'b0100);
    check("op00 pop", rd_pop, 3'd1);
    check("op00 all", rd_all, 1'b0);
    do_write(13'h0A5, 4'b1011, 2'b01, 1'b0);
    read_check("op01", 13'h0A5, 4'b1111);
    check("op01 pop", rd_pop, 3'd4);
    check("op01 all", rd_all, 1'b1);
    do_write(13'h0A5, 4'b0110, 2'b11, 1'b0);
    read_check("op11", 13'h0A5, 4'b1001);
    check("op11 pop", rd_pop, 3'd2);
    do_write(13'h0A5, 4'b1000, 2'b10, 1'b0);
    read_check("op10", 13'h0A5, 4'b0001);
    do_write(13'h0A5, 4'b0000, 2'b01, 1'b1);
    read_check("mask0", 13'h0A5, 4'b0001);
    do_write(13'h0A5, 4'b0011, 2'b00, 1'b0);
    read_check("op00 in0", 13'h0A5, 4'b0000);
    read_check("other set", 13'h0A4, 4'b0000);

    // Clear with simultaneous write; clr_req repeated mid-sweep
    do_write(13'h0000, 4'b1111, 2'b01, 1'b0);
    do_write(13'h1FFF, 4'b1111, 2'b01, 1'b0);
    read_check("pre 000", 13'h0000, 4'b1111);
    read_check("pre 1fff", 13'h1FFF, 4'b1111);
    clr_req = 1'b1;
    wr = 1'b1; wa = 13'h010; way_mask = 4'b1111; wr_op = 2'b01;
    @(negedge clk);
    clr_req = 1'b0; wr = 1'b0;
    check("clr busy", busy, 1'b1);
    read_check("clr rd_busy", 13'h0000, 4'h0);
    sweep_check("clr", 1024, 500, -1);
    read_check("clr 000", 13'h0000, 4'h0);
    read_check("clr 1fff", 13'h1FFF, 4'h0);
    read_check("clr 010", 13'h0010, 4'h0);

    // Reset mid-sweep restarts it
    do_write(13'h0A5, 4'b1111, 2'b01, 1'b0);
    read_check("pre2 0a5", 13'h0A5, 4'b1111);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    sweep_check("mid_rst", 1024, -1, 300);
    read_check("mid_rst 0a5", 13'h0A5, 4'h0);

    // Small instance: whole array in one sweep cycle
    clr_req2 = 1'b1;
    @(negedge clk);
    clr_req2 = 1'b0;
    check("d2 busy", busy2, 1'b1);
    check("d2 done0", clr_done2, 1'b0);
    @(negedge clk);
    check("d2 busy_end", busy2, 1'b0);
    check("d2 done", clr_done2, 1'b1);
    wr2 = 1'b1; wa2 = 6'd5; way_mask2 = 8'hFF; wr_op2 = 2'b01;
    @(negedge clk);
    wr2 = 1'b0; ra2 = 6'd5;
    #1;
    check("d2 done_pulse", clr_done2, 1'b0);
    check("d2 rd", rd2, 8'hFF);
    check("d2 pop8", rd_pop2, 4'd8);
    check("d2 all", rd_all2, 1'b1);
    wr2 = 1'b1; way_mask2 = 8'h0F; wr_op2 = 2'b00; in2 = 1'b0;
    @(negedge clk);
    wr2 = 1'b0;
    #1;
    check("d2 rd_f0", rd2, 8'hF0);
    check("d2 pop4", rd_pop2, 4'd4);
    check("d2 all0", rd_all2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
